// File: rtl/bcd_scan_display_pkg.sv
// bcd_display_pkg: segment patterns and scan-state encoding for the
// time-multiplexed BCD display driver (active-low, bit0=a .. bit6=g).
`timescale 1ns/1ps
package bcd_display_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    s_BLANK = 1'b0,
    s_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_scan_display_if.sv
// BCD result bus into the display driver plus the display pin outputs.
// master: the converter / bench side; slave: the display driver.
`timescale 1ns/1ps
interface bcd_scan_display_if #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1
);
  logic [DECIMAL_DIGITS*4-1:0] i_BCD;
  logic                        i_DV;
  logic [6:0]                  o_Segments;
  logic [DECIMAL_DIGITS-1:0]   o_Digit_En;
  logic [IDX_W-1:0]            o_Digit_Index;

  modport master (
    output i_BCD, i_DV,
    input  o_Segments, o_Digit_En, o_Digit_Index
  );

  modport slave (
    input  i_BCD, i_DV,
    output o_Segments, o_Digit_En, o_Digit_Index
  );
endinterface

// File: rtl/bcd_scan_display_seven_seg_decoder.sv
// seven_seg_decoder: combinational nibble -> active-low 7-segment pattern.
// Nibbles 10..15 are not BCD and show a dash so bad data is visible.
`timescale 1ns/1ps
module seven_seg_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: captures BCD results on i_DV and scans them onto a
// common-anode display, one digit at a time, with an all-off guard slot
// before each digit to avoid ghosting. All outputs are registered.
// Optional: `define LEADING_ZERO_BLANK_EN suppresses leading zero digits.
`timescale 1ns/1ps
module bcd_scan_display
  import bcd_display_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 3,
  parameter int CLKS_PER_DIGIT = 1000,
  parameter int BLANK_CLKS     = 2
)(
  input  logic             i_Clock,
  input  logic             i_Reset,
  bcd_scan_display_if.slave disp
);

  localparam int IDX_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int CNT_MAX = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CLKS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DECIMAL_DIGITS - 1);
  localparam logic [DECIMAL_DIGITS-1:0] EN_OFF = '1;

  scan_state_t                     state;
  logic [CNT_W-1:0]                cnt;
  logic [IDX_W-1:0]                idx;
  logic [DECIMAL_DIGITS-1:0][3:0]  bcd_q;
  logic [6:0]                      seg_q;
  logic [DECIMAL_DIGITS-1:0]       en_q;

  logic [6:0]                      seg_dec;
  logic                            suppress;
  logic [DECIMAL_DIGITS-1:0]       en_lit;
  logic [IDX_W-1:0]                idx_next;

  // Decode whichever digit the scan currently points at
  seven_seg_decoder u_dec (
    .nibble (bcd_q[idx]),
    .seg    (seg_dec)
  );

  // Enable pattern for the current digit and the wrapped next index
  always_comb begin
    en_lit   = ~(DECIMAL_DIGITS'(1) << idx);
    idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DECIMAL_DIGITS-1:0] shown;

  // A digit is shown if it or any higher digit is nonzero; digit 0 always
  always_comb begin
    logic nz;
    nz    = 1'b0;
    shown = '0;
    for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
      nz       = nz | (|bcd_q[k]);
      shown[k] = nz | (k == 0);
    end
    suppress = ~shown[idx];
  end
`else
  // Every digit is shown, leading zeros included
  always_comb suppress = 1'b0;
`endif

  // Capture register, scan FSM and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= s_BLANK;
      cnt   <= '0;
      idx   <= '0;
      bcd_q <= '0;
      seg_q <= SEG_OFF;
      en_q  <= EN_OFF;
    end else begin
      // last strobe wins; capture never touches the scan position
      if (disp.i_DV) bcd_q <= disp.i_BCD;
      case (state)
        s_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= s_DRIVE;
            cnt   <= '0;
            seg_q <= suppress ? SEG_OFF : seg_dec;
            en_q  <= suppress ? EN_OFF : en_lit;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        s_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state <= s_BLANK;
            cnt   <= '0;
            idx   <= idx_next;
            seg_q <= SEG_OFF;
            en_q  <= EN_OFF;
          end else begin
            // refresh every cycle so a mid-dwell capture shows up at once
            cnt   <= cnt + CNT_W'(1);
            seg_q <= suppress ? SEG_OFF : seg_dec;
            en_q  <= suppress ? EN_OFF : en_lit;
          end
        end
        default: begin
          state <= s_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign disp.o_Segments    = seg_q;
  assign disp.o_Digit_En    = en_q;
  assign disp.o_Digit_Index = idx;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display (3 digits, 4 lit cycles, 2 guard cycles).
// The reference model derives every output from the number of edges since
// reset and the last captured value, using the frame arithmetic directly.
`timescale 1ns/1ps
module tb_bcd_scan_display;

  localparam int D  = 3;
  localparam int CP = 4;
  localparam int BL = 2;
  localparam int P  = BL + CP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // model state
  int          t   = 0;
  logic [11:0] cap = '0;
  logic [6:0]  seg_tab [16];
  logic [6:0]  exp_seg;
  logic [2:0]  exp_en;
  logic [1:0]  exp_idx;

  bcd_scan_display_if #(.DECIMAL_DIGITS(D)) bus ();

  bcd_scan_display #(
    .DECIMAL_DIGITS (D),
    .CLKS_PER_DIGIT (CP),
    .BLANK_CLKS     (BL)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .disp    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic digit_shown(input logic [11:0] v, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    return (k == 0) || ((v >> (4 * k)) != 0);
`else
    return 1'b1;
`endif
  endfunction

  // one clock: apply inputs, predict outputs after the edge, compare
  task automatic step(input logic r, input logic d, input logic [11:0] b, input string tag);
    int slot;
    logic [3:0] nib;
    rst       = r;
    bus.i_DV  = d;
    bus.i_BCD = b;
    @(posedge clk);
    if (r) begin
      t   = 0;
      cap = '0;
    end else begin
      t++;
    end
    slot    = (t / P) % D;
    exp_idx = 2'(slot);
    nib     = cap[4*slot +: 4];
    if ((t % P) >= BL && digit_shown(cap, slot)) begin
      exp_seg = seg_tab[nib];
      exp_en  = ~(3'b001 << slot);
    end else begin
      exp_seg = 7'h7F;
      exp_en  = 3'b111;
    end
    if (!r && d) cap = b;
    #1;
    total += 3;
    assert (bus.o_Segments === exp_seg) else begin
      bad++;
      $error("FAIL %s seg t=%0d got=%h exp=%h", tag, t, bus.o_Segments, exp_seg);
    end
    assert (bus.o_Digit_En === exp_en) else begin
      bad++;
      $error("FAIL %s en t=%0d got=%b exp=%b", tag, t, bus.o_Digit_En, exp_en);
    end
    assert (bus.o_Digit_Index === exp_idx) else begin
      bad++;
      $error("FAIL %s idx t=%0d got=%0d exp=%0d", tag, t, bus.o_Digit_Index, exp_idx);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, tag);
  endtask

  // idle until the next step lands on frame phase ph (bounded by one frame)
  task automatic idle_to_phase(input int ph, input string tag);
    for (int i = 0; i < D * P && ((t + 1) % (D * P)) != ph; i++)
      step(1'b0, 1'b0, 12'h000, tag);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    bus.i_DV  = 1'b0;
    bus.i_BCD = '0;

    // reset state and two idle frames showing 000
    step(1'b1, 1'b0, 12'h000, "reset");
    step(1'b1, 1'b0, 12'h000, "reset");
    idle(2 * D * P, "idle_frame");

    // 709 across a full frame
    step(1'b0, 1'b1, 12'h709, "cap_709");
    idle(D * P + 2, "show_709");

    // leading zeros present (suppressed only with the option)
    step(1'b0, 1'b1, 12'h042, "cap_042");
    idle(D * P + 2, "show_042");

    // invalid nibble shows a dash
    step(1'b0, 1'b1, 12'h0A0, "cap_0A0");
    idle(D * P + 2, "show_0A0");

    // capture mid-dwell of digit 1 (phase 9 is its second lit cycle)
    idle_to_phase(9, "to_mid1");
    step(1'b0, 1'b1, 12'h350, "mid_cap");
    idle(P, "mid_after");

    // back-to-back strobes: last wins
    step(1'b0, 1'b1, 12'h111, "b2b_a");
    step(1'b0, 1'b1, 12'h986, "b2b_b");
    idle(D * P, "b2b_show");

    // reset with a strobe during drive of digit 2 (phase 15)
    idle_to_phase(15, "to_d2");
    step(1'b1, 1'b1, 12'h777, "rst_dv");
    idle(D * P + 2, "after_rst");

    // randomized traffic: random values, sparse strobes, rare resets
    for (int i = 0; i < 400; i++) begin
      logic [11:0] v;
      v = 12'($urandom);
      case ($urandom_range(0, 3))
        0: v[11:4] = '0;
        1: v[11:8] = '0;
        default: ;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0), v, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed 7-segment display driver that consumes the packed BCD word and data-valid strobe produced by the binary-to-BCD converter. It captures each new result and drives one digit at a time. Each digit gets a short all-off guard interval before it is lit, to prevent ghosting. It is the final stage between the arithmetic datapath and the board's common-anode display pins.

## Interface
- DECIMAL_DIGITS, 3: number of BCD digits and display positions (≥1).
- CLKS_PER_DIGIT, 1000: cycles each digit is lit (≥1).
- BLANK_CLKS, 2: guard cycles, all digits off, before each digit is lit (≥1).
- i_Clock  in  1  single clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_BCD  in  DECIMAL_DIGITS*4  packed BCD; digit k at [4k+3:4k], digit 0 least significant.
- i_DV  in  1  one-cycle strobe; i_BCD valid while high.
- o_Segments  out  7  active-low segments; bit0=a … bit6=g.
- o_Digit_En  out  DECIMAL_DIGITS  active-low digit enables; at most one low at any time.
- o_Digit_Index  out  $clog2(DECIMAL_DIGITS) (min 1)  index of the digit currently being scanned.

## Operation
- Reset values: o_Segments=7'h7F, o_Digit_En all ones, o_Digit_Index=0, captured value=0, state s_BLANK, cycle counter=0.
- Capture: every cycle with i_DV=1, i_BCD is loaded into the display register. No handshake, no backpressure. Back-to-back strobes are legal; the last one wins. i_BCD is ignored while i_DV=0.
- State machine:
  - s_BLANK: o_Digit_En all ones, o_Segments=7'h7F. After BLANK_CLKS cycles → s_DRIVE.
  - s_DRIVE: o_Digit_En[index] low; o_Segments shows the decoded digit. After CLKS_PER_DIGIT cycles → s_BLANK and index advances.
- Index sequence: 0,1,…,DECIMAL_DIGITS-1, then wraps to 0. With DECIMAL_DIGITS=1, the index stays 0.
- Decode for nibbles 0–9: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Decode for nibbles 10–15 (invalid BCD): dash, 7'h3F (g only).
- Capture during s_DRIVE: the lit digit changes mid-dwell. The scan position and counters are never disturbed by a capture.
- i_Reset wins over i_DV in the same cycle; the capture is discarded.
- i_Reset mid-scan returns every register to its reset value on that edge.

## Timing
- All outputs are registered.
- Capture latency: i_DV high at edge N loads the register at N. The new segment pattern appears at edge N+1 if that digit is being driven.
- Digit period = BLANK_CLKS + CLKS_PER_DIGIT cycles. Frame = DECIMAL_DIGITS × digit period.
- After reset deassert, o_Digit_En[0] goes low on the BLANK_CLKS-th rising edge with i_Reset=0. It returns high CLKS_PER_DIGIT edges later.
- o_Digit_Index changes on the same edge that enters s_BLANK.
- Cycle counter width: $clog2(max(CLKS_PER_DIGIT,BLANK_CLKS)). The counter resets on each state change; no free-running wrap.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero digit are suppressed during their s_DRIVE slot: o_Segments=7'h7F, o_Digit_En stays all ones.
  - Scan timing is unchanged.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - Suppression is evaluated on the captured value each cycle.
- Not defined: every digit is shown, including leading zeros.

## Structure
- Package bcd_display_pkg holds:
  - segment-pattern constants SEG_0…SEG_9, SEG_DASH, SEG_OFF;
  - state encodings s_BLANK and s_DRIVE.
- One sub-module, seven_seg_decoder: combinational 4-bit nibble → 7-bit active-low pattern, including the dash for 10–15. The top level registers its output.

## Test plan
- Reset release, DECIMAL_DIGITS=3, CLKS_PER_DIGIT=4, BLANK_CLKS=2, no i_DV:
  - o_Digit_En stays 3'b111 for 2 cycles, then 3'b110 for 4 cycles with o_Segments=7'h40;
  - digits 1 and 2 follow the same pattern;
  - frame repeats every 18 cycles.
- i_DV with i_BCD=12'h709:
  - digit 0 shows 7'h10, digit 1 shows 7'h40, digit 2 shows 7'h78;
  - with LEADING_ZERO_BLANK_EN and i_BCD=12'h042, digit 2 stays off.
- i_DV with i_BCD=12'h0A0 → digit 1 shows 7'h3F.
- i_DV asserted mid-dwell of digit 1 → o_Segments changes exactly one edge after capture; o_Digit_En and o_Digit_Index timing is unaffected.
- i_Reset and i_DV asserted in the same cycle during s_DRIVE of digit 2 → all outputs return to reset values; captured value is 0; scan restarts at digit 0.
